// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Memory stage of the five-stage pipeline. Takes the EX/MEM register outputs,
// runs RV32I loads and stores against a data-memory port that uses a
// request/response handshake, and drives the MEM/WB register. It stalls the
// upstream pipeline while a bus transaction is outstanding. It also handles
// byte-lane steering, load sign/zero extension and alignment/legality
// checking.
//
// Ports
//   clk               pipeline clock
//   reset             synchronous, active-low reset
//   me_alu_out        effective address for memory ops, ALU result otherwise
//   me_rs2_data_st    store data
//   me_rd             destination register
//   me_func3          load/store width and signedness
//   me_mem_read_ena   load
//   me_mem_write_ena  store (wins when both enables are set)
//   me_reg_write_ena  writeback enable
//   me_mem2reg        writeback selects load data
//   dmem_req          bus request valid
//   dmem_we           1 = store
//   dmem_addr         word-aligned bus address
//   dmem_wdata        lane-replicated store data
//   dmem_wstrb        byte strobes (0000 on loads)
//   dmem_ready        request accepted this cycle
//   dmem_rvalid       load data valid
//   dmem_rdata        load word
//   mem_stall         hold PC, IF/ID, ID/EX, EX/MEM
//   misalign_err      one-cycle pulse after a misaligned or illegal access
//   wb_alu_out        registered me_alu_out
//   wb_load_data      registered, extended load result
//   wb_rd             registered me_rd
//   wb_reg_write_ena  registered writeback enable (0 during stall bubbles)
//   wb_mem2reg        registered me_mem2reg
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       me_alu_out,
  input  logic [31:0]       me_rs2_data_st,
  input  logic [4:0]        me_rd,
  input  logic [2:0]        me_func3,
  input  logic              me_mem_read_ena,
  input  logic              me_mem_write_ena,
  input  logic              me_reg_write_ena,
  input  logic              me_mem2reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic [31:0]       wb_alu_out,
  output logic [31:0]       wb_load_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write_ena,
  output logic              wb_mem2reg
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t state, state_next;

  logic              op_present;
  logic              is_store;
  logic              func3_legal;
  logic              misaligned;
  logic              legal_op;
  logic              bad_op;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        func3_q;
  logic              store_q;

  logic              load_done;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_ext;

  assign op_present = me_mem_read_ena | me_mem_write_ena;
  assign is_store   = me_mem_write_ena;

  // Decode legality and alignment of the op currently presented by EX/MEM.
  always_comb begin
    func3_legal = 1'b0;
    misaligned  = 1'b0;
    if (is_store) begin
      case (me_func3)
        3'b000, 3'b001, 3'b010: func3_legal = 1'b1;
        default:                func3_legal = 1'b0;
      endcase
    end else begin
      case (me_func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: func3_legal = 1'b1;
        default:                                func3_legal = 1'b0;
      endcase
    end
    case (me_func3[1:0])
      2'b01:   misaligned = me_alu_out[0];
      2'b10:   misaligned = (me_alu_out[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign legal_op = op_present & func3_legal & ~misaligned;
  assign bad_op   = op_present & ~(func3_legal & ~misaligned);

  // Store lane steering: narrow data is replicated across all lanes so the
  // strobes alone pick the bytes that memory actually writes.
  always_comb begin
    st_wdata = me_rs2_data_st;
    st_wstrb = 4'b1111;
    case (me_func3[1:0])
      2'b00: begin
        st_wdata = {4{me_rs2_data_st[7:0]}};
        st_wstrb = 4'b0001 << me_alu_out[1:0];
      end
      2'b01: begin
        st_wdata = {2{me_rs2_data_st[15:0]}};
        st_wstrb = me_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = me_rs2_data_st;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Transaction latch: captured when a legal op leaves IDLE so the bus
  // outputs stay stable for the whole handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= '0;
      addr_lo_q <= 2'b00;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      func3_q   <= 3'b000;
      store_q   <= 1'b0;
    end else if (state == IDLE && legal_op) begin
      addr_q    <= {me_alu_out[ADDR_W-1:2], 2'b00};
      addr_lo_q <= me_alu_out[1:0];
      wdata_q   <= st_wdata;
      wstrb_q   <= is_store ? st_wstrb : 4'b0000;
      func3_q   <= me_func3;
      store_q   <= is_store;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and stall. The completion cycle (store accepted, or load data
  // returned) is the only non-IDLE cycle that lets the pipeline advance.
  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    dmem_req   = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (legal_op) begin
          state_next = REQ;
          mem_stall  = 1'b1;
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_ready && store_q) begin
          state_next = IDLE;
        end else if (dmem_ready) begin
          state_next = WAIT_R;
          mem_stall  = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          state_next = IDLE;
          load_done  = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dmem_we    = dmem_req & store_q;
  assign dmem_addr  = dmem_req ? addr_q : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;
  assign dmem_wstrb = dmem_req ? wstrb_q : 4'b0000;

  // Load extraction uses the latched low address bits and func3, since the
  // EX/MEM inputs are not relied on once the request has been issued.
  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (addr_lo_q)
      2'd0:    load_byte = dmem_rdata[7:0];
      2'd1:    load_byte = dmem_rdata[15:8];
      2'd2:    load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (func3_q[1:0])
      2'b00:   load_ext = {{24{load_byte[7] & ~func3_q[2]}}, load_byte};
      2'b01:   load_ext = {{16{load_half[15] & ~func3_q[2]}}, load_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // MEM/WB register. A stall inserts a bubble by clearing only the write
  // enable; a rejected op advances but never writes the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_err     <= 1'b0;
      wb_alu_out       <= '0;
      wb_load_data     <= '0;
      wb_rd            <= '0;
      wb_reg_write_ena <= 1'b0;
      wb_mem2reg       <= 1'b0;
    end else begin
      misalign_err <= (state == IDLE) & bad_op;
      if (!mem_stall) begin
        wb_alu_out       <= me_alu_out;
        wb_load_data     <= load_done ? load_ext : 32'h0;
        wb_rd            <= me_rd;
        wb_reg_write_ena <= me_reg_write_ena & ~((state == IDLE) & bad_op);
        wb_mem2reg       <= me_mem2reg;
      end else begin
        wb_reg_write_ena <= 1'b0;
      end
    end
  end

endmodule
